// File: rtl/rx_frame_queue_if.sv
// Bundles the RX push port and the core-side head-record read port of
// rx_frame_queue. The master drives pushes and reads; the slave is the queue.
interface rx_frame_queue_if #(
  parameter int AW = 2
);
  logic          rxfifowe;
  logic [1047:0] rx_fifo;
  logic          rxfifofull;
  logic          frame_avail;
  logic [7:0]    frame_len;
  logic [15:0]   frame_dst;
  logic [5:0]    rd_addr;
  logic [31:0]   rd_data;
  logic          rd_pop;
  logic [AW:0]   frame_count;
  logic [7:0]    drop_count;

  modport master (
    output rxfifowe, rx_fifo, rd_addr, rd_pop,
    input  rxfifofull, frame_avail, frame_len, frame_dst, rd_data,
           frame_count, drop_count
  );

  modport slave (
    input  rxfifowe, rx_fifo, rd_addr, rd_pop,
    output rxfifofull, frame_avail, frame_len, frame_dst, rd_data,
           frame_count, drop_count
  );
endinterface

// File: rtl/rx_frame_queue.sv
// Frame-granular receive queue: stores whole 1048-bit RX frame records and
// exposes the head record to the core as 33 registered 32-bit words.
module rx_frame_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            inclk,
  input  logic            inrst,
  rx_frame_queue_if.slave bus
);
  localparam int          REC_W    = 1048;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [7:0]       drop_count;
  logic [31:0]      rd_data;

  logic             full;
  logic             not_empty;
  logic             push_ok;
  logic             pop_ok;
  logic [REC_W-1:0] head;
  logic [31:0]      rd_word;

  assign full      = (count == FULL_CNT);
  assign not_empty = (count != '0);
  assign push_ok   = bus.rxfifowe && !full;
  assign pop_ok    = bus.rd_pop && not_empty;
  assign head      = mem[rd_ptr];

  // Word 32 carries the 24-bit tail of the record; anything beyond reads zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rd_word = '0;
    if (not_empty) begin
      if (bus.rd_addr < 6'd32)
        rd_word = head[{bus.rd_addr[4:0], 5'b00000} +: 32];
      else if (bus.rd_addr == 6'd32)
        rd_word = {8'h00, head[REC_W-1:1024]};
    end
  end

  // NOTE: the record store has no reset; pointers and count alone define validity.
  always_ff @(posedge inclk) begin
    if (push_ok)
      mem[wr_ptr] <= bus.rx_fifo;
  end

  always_ff @(posedge inclk or posedge inrst) begin
    if (inrst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
      rd_data    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rd_data <= rd_word;
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (bus.rxfifowe && full && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

  assign bus.rxfifofull  = full;
  assign bus.frame_avail = not_empty;
  assign bus.frame_len   = not_empty ? head[7:0]  : 8'h00;
  assign bus.frame_dst   = not_empty ? head[23:8] : 16'h0000;
  assign bus.rd_data     = rd_data;
  assign bus.frame_count = count;
  assign bus.drop_count  = drop_count;
endmodule

// File: tb/tb_rx_frame_queue.sv
// Directed testbench for rx_frame_queue: one task per scenario, each with
// inline comparisons against hand-computed values.
module tb_rx_frame_queue;
  logic inclk = 1'b0;
  logic inrst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  rx_frame_queue_if #(.AW(2)) bus ();

  rx_frame_queue #(.DEPTH(4), .AW(2)) dut (
    .inclk (inclk),
    .inrst (inrst),
    .bus   (bus.slave)
  );

  always #5 inclk = ~inclk;

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  function automatic logic [1047:0] make_rec(input logic [7:0] len, input logic [15:0] dst,
                                             input logic [31:0] w1, input logic [23:0] top);
    logic [1047:0] r;
    r = '0;
    r[7:0]       = len;
    r[23:8]      = dst;
    r[63:32]     = w1;
    r[1047:1024] = top;
    return r;
  endfunction

  task automatic idle_inputs();
    bus.rxfifowe = 1'b0;
    bus.rx_fifo  = '0;
    bus.rd_addr  = 6'd0;
    bus.rd_pop   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    inrst = 1'b1;
    tick();
    tick();
    inrst = 1'b0;
    tick();
  endtask

  task automatic push(input logic [1047:0] rec);
    bus.rxfifowe = 1'b1;
    bus.rx_fifo  = rec;
    tick();
    bus.rxfifowe = 1'b0;
  endtask

  task automatic pop();
    bus.rd_pop = 1'b1;
    tick();
    bus.rd_pop = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (bus.rxfifofull !== 1'b0) $display("FAIL rst_full got %b exp 0", bus.rxfifofull); else pass_cnt++;
    total_cnt++; if (bus.frame_avail !== 1'b0) $display("FAIL rst_avail got %b exp 0", bus.frame_avail); else pass_cnt++;
    total_cnt++; if (bus.frame_len !== 8'h00) $display("FAIL rst_len got %h exp 00", bus.frame_len); else pass_cnt++;
    total_cnt++; if (bus.frame_dst !== 16'h0000) $display("FAIL rst_dst got %h exp 0000", bus.frame_dst); else pass_cnt++;
    total_cnt++; if (bus.frame_count !== 3'd0) $display("FAIL rst_count got %0d exp 0", bus.frame_count); else pass_cnt++;
    total_cnt++; if (bus.drop_count !== 8'h00) $display("FAIL rst_drop got %h exp 00", bus.drop_count); else pass_cnt++;
    total_cnt++; if (bus.rd_data !== 32'h0) $display("FAIL rst_rd_data got %h exp 0", bus.rd_data); else pass_cnt++;
  endtask

  task automatic test_single_push();
    do_reset();
    push(make_rec(8'h1F, 16'hBEEF, 32'h11223344, 24'h0));
    total_cnt++; if (bus.frame_avail !== 1'b1) $display("FAIL t1_avail got %b exp 1", bus.frame_avail); else pass_cnt++;
    total_cnt++; if (bus.frame_len !== 8'h1F) $display("FAIL t1_len got %h exp 1f", bus.frame_len); else pass_cnt++;
    total_cnt++; if (bus.frame_dst !== 16'hBEEF) $display("FAIL t1_dst got %h exp beef", bus.frame_dst); else pass_cnt++;
    bus.rd_addr = 6'd1;
    tick();
    total_cnt++; if (bus.rd_data !== 32'h11223344) $display("FAIL t1_word1 got %h exp 11223344", bus.rd_data); else pass_cnt++;
    bus.rd_addr = 6'd0;
    tick();
    total_cnt++; if (bus.rd_data !== 32'h00BEEF1F) $display("FAIL t1_word0 got %h exp 00beef1f", bus.rd_data); else pass_cnt++;
    pop();
    total_cnt++; if (bus.frame_avail !== 1'b0) $display("FAIL t1_pop_avail got %b exp 0", bus.frame_avail); else pass_cnt++;
    total_cnt++; if (bus.frame_len !== 8'h00) $display("FAIL t1_pop_len got %h exp 00", bus.frame_len); else pass_cnt++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++)
      push(make_rec(8'h10 + 8'(i), 16'h1000 + 16'(i), 32'hB000_0000 + i, 24'h0));
    total_cnt++; if (bus.rxfifofull !== 1'b1) $display("FAIL t2_full got %b exp 1", bus.rxfifofull); else pass_cnt++;
    total_cnt++; if (bus.frame_count !== 3'd4) $display("FAIL t2_count got %0d exp 4", bus.frame_count); else pass_cnt++;
    push(make_rec(8'h99, 16'h9999, 32'h0, 24'h0));
    total_cnt++; if (bus.drop_count !== 8'h01) $display("FAIL t2_drop1 got %h exp 01", bus.drop_count); else pass_cnt++;
    total_cnt++; if (bus.frame_count !== 3'd4) $display("FAIL t2_count_after_drop got %0d exp 4", bus.frame_count); else pass_cnt++;
    total_cnt++; if (bus.frame_len !== 8'h10) $display("FAIL t2_head got %h exp 10", bus.frame_len); else pass_cnt++;
    bus.rxfifowe = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    bus.rxfifowe = 1'b0;
    total_cnt++; if (bus.drop_count !== 8'hFF) $display("FAIL t2_drop_sat got %h exp ff", bus.drop_count); else pass_cnt++;
    total_cnt++; if (bus.frame_dst !== 16'h1000) $display("FAIL t2_head_dst got %h exp 1000", bus.frame_dst); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++)
      push(make_rec(8'h10 + 8'(i), 16'h1000 + 16'(i), 32'h0, 24'h0));
    bus.rd_pop = 1'b1;
    push(make_rec(8'h77, 16'h7777, 32'h0, 24'h0));
    bus.rd_pop = 1'b0;
    total_cnt++; if (bus.frame_count !== 3'd3) $display("FAIL t3_count got %0d exp 3", bus.frame_count); else pass_cnt++;
    total_cnt++; if (bus.drop_count !== 8'h01) $display("FAIL t3_drop got %h exp 01", bus.drop_count); else pass_cnt++;
    total_cnt++; if (bus.frame_len !== 8'h11) $display("FAIL t3_head_len got %h exp 11", bus.frame_len); else pass_cnt++;
    total_cnt++; if (bus.rxfifofull !== 1'b0) $display("FAIL t3_full got %b exp 0", bus.rxfifofull); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(make_rec(8'h20, 16'h2000, 32'h0, 24'h0));
    bus.rd_pop = 1'b1;
    push(make_rec(8'h21, 16'h2001, 32'hC0DE_0021, 24'h0));
    bus.rd_pop = 1'b0;
    total_cnt++; if (bus.frame_count !== 3'd1) $display("FAIL t4_count got %0d exp 1", bus.frame_count); else pass_cnt++;
    total_cnt++; if (bus.frame_len !== 8'h21) $display("FAIL t4_head got %h exp 21", bus.frame_len); else pass_cnt++;
    pop();
    // Empty queue: push+pop together keeps the push, ignores the pop.
    bus.rd_pop = 1'b1;
    push(make_rec(8'h22, 16'h2002, 32'h0, 24'h0));
    bus.rd_pop = 1'b0;
    total_cnt++; if (bus.frame_count !== 3'd1) $display("FAIL t4_empty_pp_count got %0d exp 1", bus.frame_count); else pass_cnt++;
    total_cnt++; if (bus.frame_len !== 8'h22) $display("FAIL t4_empty_pp_head got %h exp 22", bus.frame_len); else pass_cnt++;
    pop();
    bus.rd_addr = 6'd1;
    pop();
    total_cnt++; if (bus.frame_count !== 3'd0) $display("FAIL t4_empty_pop_count got %0d exp 0", bus.frame_count); else pass_cnt++;
    total_cnt++; if (bus.rd_data !== 32'h0) $display("FAIL t4_empty_rd got %h exp 0", bus.rd_data); else pass_cnt++;
    push(make_rec(8'h23, 16'h2003, 32'h0, 24'h0));
    total_cnt++; if (bus.frame_len !== 8'h23) $display("FAIL t4_ptr_hold got %h exp 23", bus.frame_len); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++)
      push(make_rec(8'h30 + 8'(i), 16'h3000 + 16'(i), 32'hA000_0000 + i, 24'hC0_0000 + 24'(i)));
    for (int i = 3; i <= 10; i++) begin
      bus.rd_pop = 1'b1;
      push(make_rec(8'h30 + 8'(i), 16'h3000 + 16'(i), 32'hA000_0000 + i, 24'hC0_0000 + 24'(i)));
      bus.rd_pop = 1'b0;
      total_cnt++;
      if (bus.frame_len !== 8'h30 + 8'(i - 2))
        $display("FAIL t5_order_%0d got %h exp %h", i, bus.frame_len, 8'h30 + 8'(i - 2));
      else pass_cnt++;
    end
    bus.rd_addr = 6'd32;
    tick();
    total_cnt++; if (bus.rd_data !== 32'h00C00008) $display("FAIL t5_word32 got %h exp 00c00008", bus.rd_data); else pass_cnt++;
    bus.rd_addr = 6'd40;
    tick();
    total_cnt++; if (bus.rd_data !== 32'h0) $display("FAIL t5_word40 got %h exp 0", bus.rd_data); else pass_cnt++;
    bus.rd_addr = 6'd1;
    pop();
    total_cnt++; if (bus.rd_data !== 32'hA0000008) $display("FAIL t5_read_pop got %h exp a0000008", bus.rd_data); else pass_cnt++;
    total_cnt++; if (bus.frame_dst !== 16'h3009) $display("FAIL t5_next_head got %h exp 3009", bus.frame_dst); else pass_cnt++;
    pop();
    total_cnt++; if (bus.frame_len !== 8'h3A) $display("FAIL t5_last_head got %h exp 3a", bus.frame_len); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++)
      push(make_rec(8'h40 + 8'(i), 16'h4000 + 16'(i), 32'h0, 24'h0));
    bus.rd_addr = 6'd0;
    tick();
    #2;
    inrst = 1'b1;
    #1;
    total_cnt++; if (bus.frame_avail !== 1'b0) $display("FAIL t6_avail got %b exp 0", bus.frame_avail); else pass_cnt++;
    total_cnt++; if (bus.frame_count !== 3'd0) $display("FAIL t6_count got %0d exp 0", bus.frame_count); else pass_cnt++;
    total_cnt++; if (bus.frame_len !== 8'h00) $display("FAIL t6_len got %h exp 00", bus.frame_len); else pass_cnt++;
    total_cnt++; if (bus.rd_data !== 32'h0) $display("FAIL t6_rd_data got %h exp 0", bus.rd_data); else pass_cnt++;
    tick();
    inrst = 1'b0;
    tick();
    push(make_rec(8'h55, 16'h5555, 32'h0, 24'h0));
    total_cnt++; if (bus.frame_count !== 3'd1) $display("FAIL t6_repush_count got %0d exp 1", bus.frame_count); else pass_cnt++;
    total_cnt++; if (bus.frame_dst !== 16'h5555) $display("FAIL t6_repush_dst got %h exp 5555", bus.frame_dst); else pass_cnt++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_push();
    test_full();
    test_full_push_pop();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
